// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-select encoding, RV32I opcode constants,
// default datapath widths and the issue-stage FSM state type.
package alu_pkg;

    localparam int unsigned DEF_XLEN       = 32;
    localparam int unsigned DEF_SEL_SIZE   = 4;
    localparam int unsigned DEF_SHIFT_SIZE = 5;

    // ALU op-select encoding, shared with the ALU itself
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLT   = 4'd2,
        ALU_SLTU  = 4'd3,
        ALU_AND   = 4'd4,
        ALU_OR    = 4'd5,
        ALU_XOR   = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    // RV32I major opcodes handled by the ALU path
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 patterns
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Issue-stage occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Purely combinational RV32I ALU-instruction decoder.
// Ports:
//   instr, pc, rs1_data, rs2_data  - instruction word, its address, register operands
//   sel, shift_amt, data_a, data_b - ALU op select, shift amount and operands
//   rd_addr, rd_write, illegal     - destination, write enable, illegal flag
// Illegal encodings decode to ADD with zero operands and no register write.
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned SEL_SIZE   = DEF_SEL_SIZE,
    parameter int unsigned SHIFT_SIZE = DEF_SHIFT_SIZE
) (
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic [SEL_SIZE-1:0]   sel,
    output logic [SHIFT_SIZE-1:0] shift_amt,
    output logic [XLEN-1:0]       data_a,
    output logic [XLEN-1:0]       data_b,
    output logic [4:0]            rd_addr,
    output logic                  rd_write,
    output logic                  illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    alu_op_e               op;
    logic                  legal;
    logic [XLEN-1:0]       a_raw;
    logic [XLEN-1:0]       b_raw;
    logic [SHIFT_SIZE-1:0] shamt_raw;

    // Field extraction and legality check
    always_comb begin
        op        = ALU_ADD;
        legal     = 1'b1;
        a_raw     = '0;
        b_raw     = '0;
        shamt_raw = '0;

        unique case (opcode)
            OPC_OP: begin
                a_raw     = rs1_data;
                b_raw     = rs2_data;
                shamt_raw = rs2_data[SHIFT_SIZE-1:0];
                case (funct3)
                    3'b000:  op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
                // The alternate funct7 only exists for SUB and SRA
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                a_raw     = rs1_data;
                b_raw     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                shamt_raw = SHIFT_SIZE'(instr[24:20]);
                case (funct3)
                    3'b000:  op = ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
                // Only the shift immediates constrain the upper immediate bits
                if (funct3 == 3'b001) begin
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end
            end
            OPC_LUI: begin
                op    = ALU_LUI;
                a_raw = {{(XLEN-20){1'b0}}, instr[31:12]};
            end
            OPC_AUIPC: begin
                op    = ALU_AUIPC;
                a_raw = {{(XLEN-20){1'b0}}, instr[31:12]};
                b_raw = pc;
            end
            default: legal = 1'b0;
        endcase
    end

    // Squash everything but the destination index for illegal instructions
    always_comb begin
        sel       = SEL_SIZE'(ALU_ADD);
        shift_amt = '0;
        data_a    = '0;
        data_b    = '0;
        rd_addr   = rd;
        rd_write  = 1'b0;
        illegal   = ~legal;
        if (legal) begin
            sel       = SEL_SIZE'(op);
            shift_amt = shamt_raw;
            data_a    = a_raw;
            data_b    = b_raw;
            rd_write  = (rd != 5'd0);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// One-deep issue register with skid buffer in front of the ALU.
// Ports:
//   clk, reset, flush            - clock, sync active-high reset, pipeline flush
//   in_valid/in_ready            - upstream handshake (in_ready is a flop)
//   instr, pc, rs1_data/rs2_data - instruction and operands to decode
//   out_valid/out_ready          - downstream handshake
//   alu_enable, alu_sel, alu_shift_amt, alu_data_a/b - decoded ALU controls
//   rd_addr, rd_write, illegal   - writeback info and illegal flag
// Payload outputs read zero whenever out_valid is low.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = DEF_XLEN,
    parameter int unsigned SEL_SIZE   = DEF_SEL_SIZE,
    parameter int unsigned SHIFT_SIZE = DEF_SHIFT_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  alu_enable,
    output logic [SEL_SIZE-1:0]   alu_sel,
    output logic [SHIFT_SIZE-1:0] alu_shift_amt,
    output logic [XLEN-1:0]       alu_data_a,
    output logic [XLEN-1:0]       alu_data_b,
    output logic [4:0]            rd_addr,
    output logic                  rd_write,
    output logic                  illegal
);

    logic [SEL_SIZE-1:0]   dec_sel;
    logic [SHIFT_SIZE-1:0] dec_shift_amt;
    logic [XLEN-1:0]       dec_a;
    logic [XLEN-1:0]       dec_b;
    logic [4:0]            dec_rd_addr;
    logic                  dec_rd_write;
    logic                  dec_illegal;

    alu_op_decoder #(
        .XLEN       (XLEN),
        .SEL_SIZE   (SEL_SIZE),
        .SHIFT_SIZE (SHIFT_SIZE)
    ) u_decoder (
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .sel        (dec_sel),
        .shift_amt  (dec_shift_amt),
        .data_a     (dec_a),
        .data_b     (dec_b),
        .rd_addr    (dec_rd_addr),
        .rd_write   (dec_rd_write),
        .illegal    (dec_illegal)
    );

    issue_state_e state;
    issue_state_e state_next;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush drains both registers
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: if (in_valid) state_next = ST_FULL;
                ST_FULL: begin
                    if (out_ready && !in_valid) begin
                        state_next = ST_EMPTY;
                    end else if (!out_ready && in_valid) begin
                        state_next = ST_SKID;
                    end
                end
                ST_SKID: if (out_ready) state_next = ST_FULL;
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    logic load_main_in;
    logic load_main_skid;
    logic clear_main;
    logic load_skid;

    // Register-control decode per state
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        clear_main     = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            ST_EMPTY: load_main_in = in_valid;
            ST_FULL: begin
                if (out_ready) begin
                    load_main_in = in_valid;
                    clear_main   = ~in_valid;
                end else begin
                    load_skid = in_valid;
                end
            end
            ST_SKID: load_main_skid = out_ready;
            default: clear_main = 1'b1;
        endcase
    end

    logic [SEL_SIZE-1:0]   main_sel,   skid_sel;
    logic [SHIFT_SIZE-1:0] main_shamt, skid_shamt;
    logic [XLEN-1:0]       main_a,     skid_a;
    logic [XLEN-1:0]       main_b,     skid_b;
    logic [4:0]            main_rd,    skid_rd;
    logic                  main_wr,    skid_wr;
    logic                  main_ill,   skid_ill;
    logic                  valid_q;
    logic                  ready_q;

    // Main (output) register; kept zero while empty
    always_ff @(posedge clk) begin
        if (reset || flush || clear_main) begin
            main_sel   <= '0;
            main_shamt <= '0;
            main_a     <= '0;
            main_b     <= '0;
            main_rd    <= '0;
            main_wr    <= 1'b0;
            main_ill   <= 1'b0;
        end else if (load_main_in) begin
            main_sel   <= dec_sel;
            main_shamt <= dec_shift_amt;
            main_a     <= dec_a;
            main_b     <= dec_b;
            main_rd    <= dec_rd_addr;
            main_wr    <= dec_rd_write;
            main_ill   <= dec_illegal;
        end else if (load_main_skid) begin
            main_sel   <= skid_sel;
            main_shamt <= skid_shamt;
            main_a     <= skid_a;
            main_b     <= skid_b;
            main_rd    <= skid_rd;
            main_wr    <= skid_wr;
            main_ill   <= skid_ill;
        end
    end

    // Skid register catches the beat accepted while the output stalls
    always_ff @(posedge clk) begin
        if (reset || flush || load_main_skid) begin
            skid_sel   <= '0;
            skid_shamt <= '0;
            skid_a     <= '0;
            skid_b     <= '0;
            skid_rd    <= '0;
            skid_wr    <= 1'b0;
            skid_ill   <= 1'b0;
        end else if (load_skid) begin
            skid_sel   <= dec_sel;
            skid_shamt <= dec_shift_amt;
            skid_a     <= dec_a;
            skid_b     <= dec_b;
            skid_rd    <= dec_rd_addr;
            skid_wr    <= dec_rd_write;
            skid_ill   <= dec_illegal;
        end
    end

    // Handshake flops, computed from the next state so they track it exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            valid_q <= (state_next != ST_EMPTY);
            ready_q <= (state_next != ST_SKID);
        end
    end

    assign in_ready      = ready_q;
    assign out_valid     = valid_q;
    assign alu_enable    = valid_q;
    assign alu_sel       = main_sel;
    assign alu_shift_amt = main_shamt;
    assign alu_data_a    = main_a;
    assign alu_data_b    = main_b;
    assign rd_addr       = main_rd;
    assign rd_write      = main_wr;
    assign illegal       = main_ill;

endmodule
